// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the FSM state encoding and the header/checksum byte widths.
package inst_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int HDR_W  = 16;
   localparam int CSUM_W = 8;

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Loader bus: inbound byte stream (valid/ready) plus the instruction
// memory write port. slave = loader side, master = source/memory side.
interface inst_loader_if #(
   parameter int INST_LENGTH = 32,
   parameter int PC_LENGTH   = 32
);
   import inst_loader_pkg::*;

   logic [BYTE_W-1:0]      byteData;
   logic                   byteValid;
   logic                   byteReady;
   logic                   wrEn;
   logic [PC_LENGTH-1:0]   wrAddr;
   logic [INST_LENGTH-1:0] wrData;

   modport slave (
      input  byteData, byteValid,
      output byteReady, wrEn, wrAddr, wrData
   );

   modport master (
      output byteData, byteValid,
      input  byteReady, wrEn, wrAddr, wrData
   );

endinterface

// File: rtl/inst_loader_byte_packer.sv
// Packs big-endian bytes into a word. Ports: i_en shifts i_byte in;
// o_word = word with i_byte as its low byte; o_last = i_byte completes it.
module inst_loader_byte_packer
   import inst_loader_pkg::*;
#(
   parameter int INST_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  logic [BYTE_W-1:0]      i_byte,
   output logic [INST_LENGTH-1:0] o_word,
   output logic                   o_last
);

   logic [INST_LENGTH-1:0] r_shift;
   logic [1:0]             r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_en) begin
         r_shift <= o_word;
         r_cnt   <= r_cnt + 2'd1;
      end
   end

   assign o_word = {r_shift[INST_LENGTH-BYTE_W-1:0], i_byte};
   assign o_last = (r_cnt == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: header N, 4N data bytes, XOR checksum; writes words to
// imem via bus (slave), holds cpuRst until done; err on bad image.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int INST_LENGTH = 32,
   parameter int PC_LENGTH   = 32,
   parameter int MAX_WORDS   = 1024
) (
   input  logic          clk,
   input  logic          rst,
   inst_loader_if.slave  bus,
   output logic          cpuRst,
   output logic          done,
   output logic          err
);

   localparam int IDX_W = $clog2(MAX_WORDS) + 1;

   state_t                 r_state;
   state_t                 w_next;
   logic [HDR_W-1:0]       r_n;
   logic [IDX_W-1:0]       r_wordIdx;
   logic [IDX_W-1:0]       w_idxInc;
   logic [CSUM_W-1:0]      r_csum;
   logic [PC_LENGTH-1:0]   r_wrAddr;
   logic [INST_LENGTH-1:0] r_wrData;
   logic [INST_LENGTH-1:0] w_word;
   logic [HDR_W-1:0]       w_hdrN;
   logic                   w_ready;
   logic                   w_wrEn;
   logic                   w_accept;
   logic                   w_last;

   assign w_accept = bus.byteValid & w_ready;
   assign w_hdrN   = {r_n[HDR_W-1:BYTE_W], bus.byteData};
   assign w_idxInc = r_wordIdx + IDX_W'(1);

   inst_loader_byte_packer #(
      .INST_LENGTH (INST_LENGTH)
   ) u_pack (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_accept && (r_state == S_DATA)),
      .i_byte (bus.byteData),
      .o_word (w_word),
      .o_last (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_HDR_HI;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_wrEn  = 1'b0;
      unique case (r_state)
         S_HDR_HI: begin
            w_ready = 1'b1;
            if (bus.byteValid) w_next = S_HDR_LO;
         end
         S_HDR_LO: begin
            w_ready = 1'b1;
            if (bus.byteValid) begin
               if (w_hdrN == '0)
                  w_next = S_CSUM;
               else if ({16'b0, w_hdrN} > MAX_WORDS)
                  w_next = S_ERR;
               else
                  w_next = S_DATA;
            end
         end
         S_DATA: begin
            w_ready = 1'b1;
            if (bus.byteValid && w_last) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_wrEn = 1'b1;
            if (HDR_W'(w_idxInc) == r_n) w_next = S_CSUM;
            else                         w_next = S_DATA;
         end
         S_CSUM: begin
            w_ready = 1'b1;
            if (bus.byteValid) begin
               if (bus.byteData == r_csum) w_next = S_DONE;
               else                        w_next = S_ERR;
            end
         end
         S_DONE, S_ERR: w_next = r_state;
         default: w_next = S_HDR_HI;
      endcase
   end

   // Write address/data are captured with the 4th byte so they are
   // stable during WRITE and hold afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n       <= '0;
         r_wordIdx <= '0;
         r_csum    <= '0;
         r_wrAddr  <= '0;
         r_wrData  <= '0;
      end else begin
         if (w_accept && (r_state != S_CSUM))
            r_csum <= r_csum ^ bus.byteData;
         if (w_accept && (r_state == S_HDR_HI))
            r_n[HDR_W-1:BYTE_W] <= bus.byteData;
         if (w_accept && (r_state == S_HDR_LO))
            r_n[BYTE_W-1:0] <= bus.byteData;
         if (w_accept && (r_state == S_DATA) && w_last) begin
            r_wrData <= w_word;
            r_wrAddr <= PC_LENGTH'({r_wordIdx, 2'b00});
         end
         if (r_state == S_WRITE)
            r_wordIdx <= w_idxInc;
      end
   end

   // Ready is forced low while reset is held.
   assign bus.byteReady = w_ready & ~rst;
   assign bus.wrEn      = w_wrEn;
   assign bus.wrAddr    = r_wrAddr;
   assign bus.wrData    = r_wrData;
   assign cpuRst        = (r_state != S_DONE);
   assign done          = (r_state == S_DONE);
   assign err           = (r_state == S_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed and random images
// against an image-level model of expected writes and final status.
module tb_inst_loader;
   import inst_loader_pkg::*;

   localparam int MAXW = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpuRst, done, err;

   inst_loader_if #(.INST_LENGTH(32), .PC_LENGTH(32)) bus ();

   inst_loader #(
      .INST_LENGTH (32),
      .PC_LENGTH   (32),
      .MAX_WORDS   (MAXW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .cpuRst (cpuRst),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          gap_pct  = 0;
   wr_t         exp_wr[$];
   logic [7:0]  img[$];
   logic        prev_we  = 1'b0;
   logic [31:0] hold_a   = '0;
   logic [31:0] hold_d   = '0;
   wr_t         e;

   task automatic chk_eq(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the expected write queue
   initial begin : cmp
      forever begin
         @(negedge clk);
         if (rst) begin
            chk_eq("rst_ready", bus.byteReady, 0);
            chk_eq("rst_wrEn", bus.wrEn, 0);
            chk_eq("rst_wrAddr", bus.wrAddr, 0);
            chk_eq("rst_wrData", bus.wrData, 0);
            chk_eq("rst_cpuRst", cpuRst, 1);
            chk_eq("rst_done", done, 0);
            chk_eq("rst_err", err, 0);
            hold_a  = '0;
            hold_d  = '0;
            prev_we = 1'b0;
         end else begin
            chk_eq("done_err_excl", done & err, 0);
            chk_eq("cpuRst_vs_done", cpuRst, !done);
            if (bus.wrEn) begin
               chk_eq("wrEn_pulse", prev_we, 0);
               chk_eq("ready_in_write", bus.byteReady, 0);
               if (exp_wr.size() == 0) begin
                  chk_eq("unexpected_write", exp_wr.size(), 1);
               end else begin
                  e = exp_wr.pop_front();
                  chk_eq("wrAddr", bus.wrAddr, e.addr);
                  chk_eq("wrData", bus.wrData, e.data);
                  hold_a = e.addr;
                  hold_d = e.data;
               end
            end else begin
               chk_eq("hold_wrAddr", bus.wrAddr, hold_a);
               chk_eq("hold_wrData", bus.wrData, hold_d);
            end
            prev_we = bus.wrEn;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output bit ok);
      int waited;
      bit acc;
      waited = 0;
      ok = 0;
      bus.byteData  = b;
      bus.byteValid = 1'b1;
      while (!ok && waited < 50) begin
         @(negedge clk);
         acc = bus.byteReady;
         @(posedge clk);
         #1;
         if (acc) ok = 1;
         else     waited++;
      end
      bus.byteValid = 1'b0;
      if (!ok) chk_eq("accept_timeout", waited, 0);
      if ($urandom_range(99) < gap_pct) begin
         repeat ($urandom_range(3, 1)) begin
            bus.byteData = 8'($urandom);
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk_eq("ready_after_rst", bus.byteReady, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.byteValid = 1'b0;
      #2 rst = 1'b1;
      exp_wr.delete();
      repeat (2) @(posedge clk);
      release_rst();
   endtask

   // Model: derive expected writes and outcome straight from the image
   task automatic run_image();
      int n, consumed;
      bit exp_done, ok;
      logic [7:0] x;
      n = int'({img[0], img[1]});
      exp_done = 0;
      if (n > MAXW) begin
         consumed = 2;
      end else begin
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x ^= img[i];
         for (int w = 0; w < n; w++)
            exp_wr.push_back('{addr: 32'(w * 4),
                               data: {img[2+4*w], img[3+4*w],
                                      img[4+4*w], img[5+4*w]}});
         consumed = 3 + 4 * n;
         exp_done = (img[2 + 4 * n] == x);
      end
      for (int i = 0; i < consumed; i++) begin
         send_byte(img[i], ok);
         if (!ok) break;
      end
      repeat (2) @(negedge clk);
      chk_eq("final_done", done, exp_done);
      chk_eq("final_err", err, !exp_done);
      chk_eq("final_cpuRst", cpuRst, !exp_done);
      chk_eq("pending_writes", exp_wr.size(), 0);
      bus.byteData  = 8'hA5;
      bus.byteValid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_eq("terminal_ready", bus.byteReady, 0);
      end
      bus.byteValid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic make_image(input int n, input bit good);
      logic [7:0] x, b;
      img.delete();
      img.push_back(n[15:8]);
      img.push_back(n[7:0]);
      x = n[15:8] ^ n[7:0];
      if (n <= MAXW) begin
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
            x ^= b;
         end
         img.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
      end
   endtask

   initial begin : wdog
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      bit ok;
      int n;
      bus.byteData  = 8'h00;
      bus.byteValid = 1'b0;
      repeat (2) @(posedge clk);
      release_rst();

      gap_pct = 30;
      img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run_image();
      chk_eq("t1_wrAddr", bus.wrAddr, 32'h0);
      chk_eq("t1_wrData", bus.wrData, 32'h12345678);
      chk_eq("t1_done", done, 1);

      do_reset();
      gap_pct = 0;
      img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
      run_image();
      chk_eq("t2_wrAddr", bus.wrAddr, 32'h4);
      chk_eq("t2_wrData", bus.wrData, 32'h0);
      chk_eq("t2_done", done, 1);

      do_reset();
      img = '{8'h00, 8'h00, 8'h00};
      run_image();
      chk_eq("t3_done", done, 1);
      do_reset();
      img = '{8'h00, 8'h00, 8'hFF};
      run_image();
      chk_eq("t3_err", err, 1);
      chk_eq("t3_cpuRst", cpuRst, 1);

      do_reset();
      img = '{8'h04, 8'h01};
      run_image();
      chk_eq("t4_err", err, 1);
      chk_eq("t4_wrAddr", bus.wrAddr, 32'h0);

      do_reset();
      gap_pct = 20;
      img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24};
      run_image();
      chk_eq("t5_wrData", bus.wrData, 32'hDEADBEEF);
      chk_eq("t5_err", err, 1);
      chk_eq("t5_done", done, 0);

      do_reset();
      send_byte(8'h00, ok);
      send_byte(8'h01, ok);
      send_byte(8'hAA, ok);
      send_byte(8'hBB, ok);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_eq("t6_ready", bus.byteReady, 0);
      chk_eq("t6_wrEn", bus.wrEn, 0);
      chk_eq("t6_cpuRst", cpuRst, 1);
      chk_eq("t6_done", done, 0);
      chk_eq("t6_err", err, 0);
      exp_wr.delete();
      release_rst();
      img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      run_image();
      chk_eq("t6_wrAddr", bus.wrAddr, 32'h0);
      chk_eq("t6_wrData", bus.wrData, 32'h11223344);
      chk_eq("t6_done2", done, 1);

      do_reset();
      gap_pct = 0;
      make_image(MAXW, 1);
      run_image();
      chk_eq("t7_lastAddr", bus.wrAddr, 32'hFFC);
      chk_eq("t7_done", done, 1);

      for (int k = 0; k < 30; k++) begin
         do_reset();
         gap_pct = $urandom_range(50);
         case ($urandom_range(9))
            0:       n = $urandom_range(65535, MAXW + 1);
            1:       n = 0;
            default: n = $urandom_range(6, 1);
         endcase
         make_image(n, $urandom_range(3) != 0);
         run_image();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory in the SOC.
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes each word into the instruction memory's write port.
- Holds the MIPS core in reset until a complete image with a good checksum has been loaded.

Parameters:
INST_LENGTH, 32, instruction word width (matches the `INST_LENGTH` constant)
PC_LENGTH, 32, byte-address width of the instruction memory write port
MAX_WORDS, 1024, instruction memory capacity in words; larger headers are rejected

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
byteData  input  8  incoming image byte
byteValid  input  1  byteData is valid this cycle
byteReady  output  1  loader accepts byteData this cycle
wrEn  output  1  instruction memory write strobe, one-cycle pulse
wrAddr  output  PC_LENGTH  byte address of the word being written (word index × 4)
wrData  output  INST_LENGTH  word being written
cpuRst  output  1  reset request to the MIPS core; high until load succeeds
done  output  1  image loaded and verified
err  output  1  load failed (oversize header or checksum mismatch)

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to HDR_HI; word and byte counters, checksum register and shift register clear to 0.
  - Outputs: byteReady=0 while rst is high, 1 in the first cycle after release; wrEn=0, wrAddr=0, wrData=0, cpuRst=1, done=0, err=0.
  - Reset mid-load aborts immediately and restarts at HDR_HI. No partial write completes.
- A byte is accepted in any cycle where byteValid && byteReady.
- byteReady=1 only in HDR_HI, HDR_LO, DATA and CSUM. Otherwise 0.
- Image format: 16-bit word count N, big-endian (2 bytes); then 4N data bytes, each word big-endian (first byte → bits 31:24); then 1 checksum byte.
- Checksum: 8-bit XOR of every byte from the first header byte through the last data byte.
- States and transitions:
  - HDR_HI: accept byte → N[15:8], go to HDR_LO.
  - HDR_LO: accept byte → N[7:0]. Then:
    - N==0 → CSUM.
    - N>MAX_WORDS → ERR.
    - otherwise → DATA.
  - DATA: accept byte, shift it into the word register, increment the byte-in-word counter (2-bit, wraps). On the 4th byte go to WRITE.
  - WRITE (exactly one cycle):
    - wrEn=1, wrData=assembled word, wrAddr={wordIdx, 2'b00}; byteReady=0.
    - Then wordIdx+1. Go to CSUM if wordIdx+1==N, else back to DATA.
  - CSUM: accept byte. Match → DONE; mismatch → ERR.
  - DONE (terminal): done=1, cpuRst=0 from the first cycle in DONE.
  - ERR (terminal): err=1, cpuRst stays 1. Only rst leaves DONE or ERR.
- Latency: the 4th byte of a word is accepted in cycle t; wrEn is high in cycle t+1 and the next byte can be accepted in t+2.
- wrAddr and wrData hold their last values when wrEn=0.
- byteValid low stalls any accepting state indefinitely with no state change.
- Bytes presented in DONE or ERR are not accepted (byteReady=0).
- done and err are never high together.
- wordIdx is sized clog2(MAX_WORDS)+1 bits. N==MAX_WORDS is legal and the last wrAddr is (MAX_WORDS-1)×4.

Decomposition:
- InstLoader.vh holds the state encodings (HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR) and the header/checksum byte widths.
- Width constants are reused from the existing MIPS.vh / InstMem.vh.
- One optional sub-module, byte_packer (shift register plus 2-bit byte counter, word-complete flag). The FSM, counters and checksum stay in inst_loader.
- SOC integration: cpuRst ORed with rst into the mips_m reset; wrEn/wrAddr/wrData go to a new write port on InstMem.

Test Plan:
- Reset, then bytes 00 01 12 34 56 78 and checksum 0x09 (0x00^0x01^0x12^0x34^0x56^0x78) → one wrEn pulse, wrAddr=0, wrData=0x12345678; then done=1, cpuRst=0, err=0.
- N=2, words 0x20010005 and 0x00000000, correct checksum, byteValid held high → wrEn at addresses 0 and 4; byteReady low exactly in each WRITE cycle; done=1.
- N=0 with checksum 0x00 → no wrEn, done=1. Same header with checksum 0xFF → err=1, cpuRst=1.
- Header 0x0401 with MAX_WORDS=1024 → err=1 after the second header byte; byteReady=0 afterwards; no writes.
- Single-word image with a wrong checksum byte → the word is still written, then err=1, cpuRst stays 1, done=0.
- rst pulsed mid-word (after 2 data bytes), then a valid 1-word image → outputs return to reset values asynchronously; the new image loads from wrAddr=0 and the stale bytes are discarded.
